seven_segment_display_reader: RTL and testbench
===============================================

# seven_segment_display_reader

Passive monitor for the multiplexed 8-digit seven-segment bus (active-low Anodes/Cathodes/DP, segment A as MSB, G as LSB) that the display driver produces. It samples each settled digit slot, decodes the segment patterns back to BCD, collects one full refresh frame, and converts it serially to a 27-bit binary value. It sits on the board-level display pins, or in the bench as a scoreboard front end, and closes the loop on the temperature readout.

## Interface
- SETTLE_CYCLES, 16: consecutive cycles an Anodes/Cathodes pattern must be unchanged before the slot is captured; minimum 2.
- Clock_100MHz  in  1  system clock.
- Clear  in  1  asynchronous, active-high reset.
- Enable  in  1  gates the settle counter and captures; a CONVERT already in progress still completes.
- Anodes  in  8  active-low digit select; bit n is position n.
- Cathodes  in  7  active-low segments A..G.
- DP  in  1  decimal point; ignored.
- Value  out  27  binary value of the last good frame.
- Digits  out  32  BCD nibbles of the last good frame; position n is bits [4n+3:4n].
- Valid  out  1  one-cycle strobe when a frame result (good, overflow or error) is published.
- Overflow  out  1  status of the last published frame: OVERFLOW pattern seen.
- Error  out  1  status of the last published frame: malformed.

## Operation
- Reset: Value=0, Digits=0, Valid=0, Overflow=0, Error=0, state IDLE, both frame buffers empty.
- Settle detector: compares {Anodes,Cathodes} with the previous cycle. On a change it reloads the counter to 0. Otherwise it increments, saturating at SETTLE_CYCLES.
- Capture: exactly once per dwell, on the cycle the counter reaches SETTLE_CYCLES-1, and only when Enable=1. All-high Anodes means a blank slot and produces no capture. More than one low anode marks the collect buffer as errored.
- Pattern decode classes:
  - 0-9 per the driver table.
  - letters U=1000001, E=0110000, R=0001000, F=0111000, L=1110001.
  - 1111111 blank.
  - anything else invalid, which sets the collect error flag.
  - O shares 0000001 with digit 0.
- Collect buffer: 8 slots, each a 4-bit code plus a present bit, plus a letter flag and an error flag.
- Frame boundary: a capture at position 0. If the collect buffer is non-empty, it is copied to the snapshot. Collect is then cleared and the new position-0 capture is written into it.
- FSM states and transitions:
  - IDLE -> CONVERT on a boundary with a non-empty snapshot.
  - CONVERT takes 8 cycles, positions 7 down to 0: acc <= (acc<<3)+(acc<<1)+digit. Absent positions count as 0.
  - CONVERT -> PUBLISH.
  - PUBLISH -> IDLE, asserting Valid for one cycle.
- Frame checks at PUBLISH:
  - A present position above an absent one is a gap, which sets Error.
  - Overflow is set when all 8 positions are present and match, positions 7..0: 0,U,E,R,F,L,0,U.
  - Any other frame containing a letter sets Error.
- Results: only a good frame updates Value and Digits. Overflow and Error are updated on every Valid.
- Arithmetic: acc is 27 bits; the maximum of 99,999,999 fits, so no saturation is needed.
- Boundary during CONVERT/PUBLISH: the snapshot is not overwritten and the completed collect frame is discarded. Collect restarts from position 0 as usual.

## Timing
- Pin change to capture: SETTLE_CYCLES cycles, plus 2 when the synchronizer is compiled in.
- Capture (boundary) cycle to Valid: 10 cycles (copy, 8 CONVERT, PUBLISH). Value, Digits and the flags are stable from the Valid cycle onward.
- A frame is published when the next frame's position-0 capture arrives, so latency is one refresh period plus the figures above.
- Clear mid-CONVERT: immediate return to reset values; no Valid.

## Configuration
- SEVEN_SEGMENT_READER_SYNC_EN defined: 2-flop synchronizers on Anodes and Cathodes, for asynchronous pins.
- Not defined: inputs are sampled directly and must be synchronous to Clock_100MHz (same-clock bench use).

## Structure
- Package seven_segment_pkg:
  - cathode pattern constants, shared with the driver.
  - code-class enum (DIGIT, LETTER, BLANK, INVALID).
  - FSM state enum.
  - OVERFLOW reference sequence.
- Sub-module segment_pattern_decoder: combinational, Cathodes -> {class, 4-bit code}.

## Test plan
- SETTLE_CYCLES=4, dwell 20 cycles per slot; drive "42" (pos0=0010010, pos1=1001100, others all-high anodes), two frames -> Valid with Value=42, Digits=32'h00000042, Overflow=0, Error=0.
- Drive 99999999 on all 8 positions -> Value=99999999, Digits=32'h99999999.
- Drive OVERFLOW (pos7..0 = 0000001,1000001,0110000,0001000,0111000,1110001,0000001,1000001) -> Overflow=1, Error=0, Value keeps 99999999.
- Pos1 Cathodes=1010101 -> Error=1, Value unchanged; next clean frame -> Error=0.
- 3-cycle glitch on pos2 cathodes inside a dwell -> no extra capture; reported value unaffected.
- Assert Clear during CONVERT -> all outputs 0 next cycle, no Valid; a following clean frame is reported normally.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display reader: cathode patterns,
// decode classes, reader FSM states and the frame buffer layout.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_R     = 7'b0001000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Letters get codes above the BCD range so a frame keeps them distinguishable
  localparam logic [3:0] CODE_U = 4'd10;
  localparam logic [3:0] CODE_E = 4'd11;
  localparam logic [3:0] CODE_R = 4'd12;
  localparam logic [3:0] CODE_F = 4'd13;
  localparam logic [3:0] CODE_L = 4'd14;

  typedef enum logic [1:0] {
    CLASS_DIGIT   = 2'd0,
    CLASS_LETTER  = 2'd1,
    CLASS_BLANK   = 2'd2,
    CLASS_INVALID = 2'd3
  } code_class_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PUBLISH = 2'd2
  } reader_state_t;

  // Position 7 in the top nibble down to position 0 in the bottom nibble
  localparam logic [31:0] OVERFLOW_CODES =
    {4'd0, CODE_U, CODE_E, CODE_R, CODE_F, CODE_L, 4'd0, CODE_U};

  typedef struct packed {
    logic [7:0]  present;
    logic [31:0] codes;
    logic        letter;
    logic        err;
  } frame_buf_t;

  localparam frame_buf_t FRAME_EMPTY =
    '{present: 8'd0, codes: 32'd0, letter: 1'b0, err: 1'b0};

  // Present positions must form a contiguous run starting at position 0
  function automatic logic frame_has_gap(input logic [7:0] present);
    return (present & (present + 8'd1)) != 8'd0;
  endfunction

  function automatic logic is_overflow_frame(input frame_buf_t f);
    return (f.present == 8'hFF) && (f.codes == OVERFLOW_CODES);
  endfunction

endpackage

// File: rtl/segment_pattern_decoder.sv
// Combinational decode of an active-low cathode pattern (A..G, A as MSB)
// into a code class and a 4-bit code.
module segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0]  cathodes,
  output code_class_t code_class,
  output logic [3:0]  code
);

  // Pattern table lookup; anything unlisted is invalid
  always_comb begin
    code_class = CLASS_INVALID;
    code       = 4'd0;
    case (cathodes)
      SEG_0:     begin code_class = CLASS_DIGIT;  code = 4'd0;   end
      SEG_1:     begin code_class = CLASS_DIGIT;  code = 4'd1;   end
      SEG_2:     begin code_class = CLASS_DIGIT;  code = 4'd2;   end
      SEG_3:     begin code_class = CLASS_DIGIT;  code = 4'd3;   end
      SEG_4:     begin code_class = CLASS_DIGIT;  code = 4'd4;   end
      SEG_5:     begin code_class = CLASS_DIGIT;  code = 4'd5;   end
      SEG_6:     begin code_class = CLASS_DIGIT;  code = 4'd6;   end
      SEG_7:     begin code_class = CLASS_DIGIT;  code = 4'd7;   end
      SEG_8:     begin code_class = CLASS_DIGIT;  code = 4'd8;   end
      SEG_9:     begin code_class = CLASS_DIGIT;  code = 4'd9;   end
      SEG_U:     begin code_class = CLASS_LETTER; code = CODE_U; end
      SEG_E:     begin code_class = CLASS_LETTER; code = CODE_E; end
      SEG_R:     begin code_class = CLASS_LETTER; code = CODE_R; end
      SEG_F:     begin code_class = CLASS_LETTER; code = CODE_F; end
      SEG_L:     begin code_class = CLASS_LETTER; code = CODE_L; end
      SEG_BLANK: begin code_class = CLASS_BLANK;  code = 4'd0;   end
      default:   begin code_class = CLASS_INVALID; code = 4'd0;  end
    endcase
  end

endmodule

// File: rtl/seven_segment_display_reader.sv
// Passive reader for the multiplexed 8-digit seven-segment bus: captures settled
// slots, rebuilds a frame and converts it to binary. SEVEN_SEGMENT_READER_SYNC_EN
// adds 2-flop synchronizers on Anodes/Cathodes for asynchronous pins.
module seven_segment_display_reader
  import seven_segment_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
)
(
  input  logic        Clock_100MHz,
  input  logic        Clear,
  input  logic        Enable,
  input  logic [7:0]  Anodes,
  input  logic [6:0]  Cathodes,
  input  logic        DP,
  output logic [26:0] Value,
  output logic [31:0] Digits,
  output logic        Valid,
  output logic        Overflow,
  output logic        Error
);

  localparam int             CNT_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [14:0]    PINS_IDLE  = {8'hFF, 7'h7F};

  logic [14:0]   pins_s;
  logic [14:0]   prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic          changed_s;
  logic          capture_s;
  logic [7:0]    anode_low_s;
  logic          one_hot_s;
  logic          multi_s;
  logic [2:0]    pos_s;
  code_class_t   cls_s;
  logic [3:0]    code_s;
  frame_buf_t    collect_r;
  frame_buf_t    collect_next_s;
  frame_buf_t    snap_r;
  logic          collect_nonempty_s;
  logic          boundary_s;
  reader_state_t state_r;
  logic [2:0]    idx_r;
  logic [26:0]   acc_r;
  logic [3:0]    digit_s;
  logic          match_s;
  logic          ovf_s;
  logic          err_s;
  logic          unused_dp_s;

  assign unused_dp_s = DP;

`ifdef SEVEN_SEGMENT_READER_SYNC_EN
  logic [14:0] sync1_r;
  logic [14:0] sync2_r;

  // Two-stage synchronizer for the asynchronous display pins
  always_ff @(posedge Clock_100MHz or posedge Clear) begin
    if (Clear) begin
      sync1_r <= PINS_IDLE;
      sync2_r <= PINS_IDLE;
    end else begin
      sync1_r <= {Anodes, Cathodes};
      sync2_r <= sync1_r;
    end
  end

  assign pins_s = sync2_r;
`else
  assign pins_s = {Anodes, Cathodes};
`endif

  assign changed_s = (pins_s != prev_r);

  // Settle counter: restarts on any pin change, saturates once the slot is stable
  always_ff @(posedge Clock_100MHz or posedge Clear) begin
    if (Clear) begin
      prev_r <= PINS_IDLE;
      cnt_r  <= CNT_ZERO;
    end else begin
      prev_r <= pins_s;
      if (!Enable || changed_s) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign capture_s   = Enable && !changed_s && (cnt_r == CNT_FIRE);
  assign anode_low_s = ~pins_s[14:7];
  assign one_hot_s   = (anode_low_s != 8'd0) &&
                       ((anode_low_s & (anode_low_s - 8'd1)) == 8'd0);
  assign multi_s     = (anode_low_s != 8'd0) && !one_hot_s;

  // Position of the (single) active anode
  always_comb begin
    pos_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (anode_low_s[i]) begin
        pos_s = 3'(i);
      end else begin
        pos_s = pos_s;
      end
    end
  end

  segment_pattern_decoder u_decoder (
    .cathodes   (pins_s[6:0]),
    .code_class (cls_s),
    .code       (code_s)
  );

  assign collect_nonempty_s = (collect_r.present != 8'd0) || collect_r.err;
  assign boundary_s         = capture_s && one_hot_s && (pos_s == 3'd0);

  // Next collect buffer; a position-0 capture starts a fresh frame
  always_comb begin
    collect_next_s = collect_r;
    if (capture_s && multi_s) begin
      collect_next_s.err = 1'b1;
    end else if (capture_s && one_hot_s) begin
      if (pos_s == 3'd0) begin
        collect_next_s = FRAME_EMPTY;
      end else begin
        collect_next_s = collect_r;
      end
      case (cls_s)
        CLASS_DIGIT: begin
          collect_next_s.present[pos_s]             = 1'b1;
          collect_next_s.codes[{pos_s, 2'b00} +: 4] = code_s;
        end
        CLASS_LETTER: begin
          collect_next_s.present[pos_s]             = 1'b1;
          collect_next_s.codes[{pos_s, 2'b00} +: 4] = code_s;
          collect_next_s.letter                     = 1'b1;
        end
        CLASS_BLANK: begin
          collect_next_s.present[pos_s]             = 1'b0;
          collect_next_s.codes[{pos_s, 2'b00} +: 4] = 4'd0;
        end
        CLASS_INVALID: collect_next_s.err = 1'b1;
        default:       collect_next_s.err = 1'b1;
      endcase
    end else begin
      collect_next_s = collect_r;
    end
  end

  // Collect buffer register
  always_ff @(posedge Clock_100MHz or posedge Clear) begin
    if (Clear) begin
      collect_r <= FRAME_EMPTY;
    end else begin
      collect_r <= collect_next_s;
    end
  end

  assign digit_s = snap_r.present[idx_r] ? snap_r.codes[{idx_r, 2'b00} +: 4] : 4'd0;
  assign match_s = is_overflow_frame(snap_r);
  assign ovf_s   = match_s && !snap_r.err;
  assign err_s   = snap_r.err || frame_has_gap(snap_r.present) ||
                   (snap_r.letter && !match_s);

  // Snapshot, serial BCD-to-binary conversion and result publication
  always_ff @(posedge Clock_100MHz or posedge Clear) begin
    if (Clear) begin
      state_r  <= ST_IDLE;
      snap_r   <= FRAME_EMPTY;
      idx_r    <= 3'd7;
      acc_r    <= 27'd0;
      Value    <= 27'd0;
      Digits   <= 32'd0;
      Valid    <= 1'b0;
      Overflow <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (boundary_s && collect_nonempty_s) begin
            snap_r  <= collect_r;
            acc_r   <= 27'd0;
            idx_r   <= 3'd7;
            state_r <= ST_CONVERT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          acc_r <= (acc_r << 3) + (acc_r << 1) + 27'(digit_s);
          if (idx_r == 3'd0) begin
            state_r <= ST_PUBLISH;
          end else begin
            idx_r <= idx_r - 3'd1;
          end
        end
        ST_PUBLISH: begin
          Valid    <= 1'b1;
          Overflow <= ovf_s;
          Error    <= err_s;
          if (!ovf_s && !err_s) begin
            Value  <= acc_r;
            Digits <= snap_r.codes;
          end
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_display_reader.sv
// Directed + randomized bench: drives multiplexed display frames and checks each
// published result against a symbolic frame model.
module tb_seven_segment_display_reader;

  localparam int S     = 4;
  localparam int DWELL = 20;
  localparam int SYM_ABSENT  = -1;
  localparam int SYM_INVALID = -2;
  localparam int SYM_U = 100;
  localparam int SYM_E = 101;
  localparam int SYM_R = 102;
  localparam int SYM_F = 103;
  localparam int SYM_L = 104;

  typedef struct packed {
    logic [7:0]  on;
    logic [55:0] pat;
  } frame_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [7:0]  an;
  logic [6:0]  ca;
  logic        dp;
  logic [26:0] value;
  logic [31:0] digits;
  logic        valid;
  logic        overflow;
  logic        error;

  int total = 0;
  int bad = 0;
  int vcount = 0;

  logic [6:0] dig_pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};
  int ovf_seq [8] = '{SYM_U, 0, SYM_L, SYM_F, SYM_R, SYM_E, SYM_U, 0};

  longint      last_val = 0;
  logic [31:0] last_dig = 32'd0;
  frame_t      prev_f;
  string       prev_tag;
  bit          have_prev = 1'b0;

  seven_segment_display_reader #(.SETTLE_CYCLES(S)) dut (
    .Clock_100MHz (clk),
    .Clear        (clr),
    .Enable       (en),
    .Anodes       (an),
    .Cathodes     (ca),
    .DP           (dp),
    .Value        (value),
    .Digits       (digits),
    .Valid        (valid),
    .Overflow     (overflow),
    .Error        (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) vcount++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sym_of(input logic [6:0] p);
    int s = SYM_INVALID;
    for (int d = 0; d < 10; d++) if (p == dig_pat[d]) s = d;
    if (p == 7'b1000001) s = SYM_U;
    if (p == 7'b0110000) s = SYM_E;
    if (p == 7'b0001000) s = SYM_R;
    if (p == 7'b0111000) s = SYM_F;
    if (p == 7'b1110001) s = SYM_L;
    if (p == 7'b1111111) s = SYM_ABSENT;
    return s;
  endfunction

  // Symbolic reference: classify each position, then apply the frame rules
  task automatic model(input frame_t f, output bit ovf, output bit err,
                       output longint val, output logic [31:0] dig);
    int sym [8];
    bit letter = 1'b0;
    bit invalid = 1'b0;
    bit gap = 1'b0;
    bit match = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sym[i] = f.on[i] ? sym_of(f.pat[i*7 +: 7]) : SYM_ABSENT;
      if (sym[i] == SYM_INVALID) invalid = 1'b1;
      if (sym[i] >= SYM_U) letter = 1'b1;
      if (sym[i] != ovf_seq[i]) match = 1'b0;
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < i; j++)
        if (sym[i] >= 0 && sym[j] < 0) gap = 1'b1;
    ovf = match && !invalid;
    err = invalid || gap || (letter && !match);
    val = 0;
    dig = 32'd0;
    for (int i = 7; i >= 0; i--) begin
      val = val * 10 + ((sym[i] >= 0 && sym[i] < 10) ? sym[i] : 0);
      dig[i*4 +: 4] = (sym[i] >= 0 && sym[i] < 10) ? 4'(sym[i]) : 4'd0;
    end
  endtask

  function automatic frame_t mk_num(input longint n, input int cnt);
    frame_t f;
    longint r = n;
    f.on  = 8'h00;
    f.pat = {56{1'b1}};
    for (int i = 0; i < cnt; i++) begin
      f.on[i] = 1'b1;
      f.pat[i*7 +: 7] = dig_pat[r % 10];
      r = r / 10;
    end
    return f;
  endfunction

  function automatic frame_t mk_random();
    frame_t f;
    int cnt = $urandom_range(1, 8);
    f.on  = 8'h00;
    f.pat = {56{1'b1}};
    for (int i = 0; i < cnt; i++) begin
      f.on[i] = 1'b1;
      f.pat[i*7 +: 7] = dig_pat[$urandom_range(0, 9)];
    end
    if (cnt >= 3 && $urandom_range(0, 3) == 0) f.on[$urandom_range(1, cnt - 2)] = 1'b0;
    return f;
  endfunction

  task automatic send_frame(input frame_t f, input int glitch_pos, input bit do_clear);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < DWELL; c++) begin
        @(negedge clk);
        if (c == 0) begin
          an = 8'hFF;
          if (f.on[p]) an[p] = 1'b0;
          ca = f.on[p] ? f.pat[p*7 +: 7] : 7'h7F;
        end
        if (p == glitch_pos && c == 8)  ca = ca ^ 7'b0000110;
        if (p == glitch_pos && c == 11) ca = f.pat[p*7 +: 7];
        if (do_clear && p == 0 && c == 7) begin
          clr = 1'b1;
          #1;
          chk("clear_value", 64'(value), 64'd0);
          chk("clear_digits", 64'(digits), 64'd0);
          chk("clear_valid", 64'(valid), 64'd0);
          chk("clear_overflow", 64'(overflow), 64'd0);
          chk("clear_error", 64'(error), 64'd0);
        end
        if (do_clear && p == 0 && c == 9) clr = 1'b0;
      end
    end
  endtask

  task automatic check_pub(input frame_t f, input int vc0, input string tag);
    bit ovf;
    bit err;
    longint val;
    logic [31:0] dig;
    model(f, ovf, err, val, dig);
    if (!ovf && !err) begin
      last_val = val;
      last_dig = dig;
    end
    chk({tag, "_valid_count"}, 64'(vcount - vc0), 64'd1);
    chk({tag, "_value"}, 64'(value), 64'(last_val));
    chk({tag, "_digits"}, 64'(digits), 64'(last_dig));
    chk({tag, "_overflow"}, 64'(overflow), 64'(ovf));
    chk({tag, "_error"}, 64'(error), 64'(err));
  endtask

  // Sending a frame publishes the previous one in this frame's position-0 slot
  task automatic run(input frame_t f, input int glitch_pos, input bit do_clear, input string tag);
    int vc0 = vcount;
    send_frame(f, glitch_pos, do_clear);
    if (do_clear) begin
      chk({tag, "_no_valid_after_clear"}, 64'(vcount - vc0), 64'd0);
      last_val = 0;
      last_dig = 32'd0;
    end else if (have_prev) begin
      check_pub(prev_f, vc0, prev_tag);
    end
    prev_f    = f;
    prev_tag  = tag;
    have_prev = 1'b1;
  endtask

  initial begin
    frame_t f;
    clr = 1'b1;
    en  = 1'b1;
    an  = 8'hFF;
    ca  = 7'h7F;
    dp  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_value", 64'(value), 64'd0);
    chk("reset_digits", 64'(digits), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    clr = 1'b0;

    run(mk_num(42, 2), -1, 1'b0, "f42");
    run(mk_num(99999999, 8), -1, 1'b0, "f99999999");

    f.on  = 8'hFF;
    f.pat = {7'b0000001, 7'b1000001, 7'b0110000, 7'b0001000,
             7'b0111000, 7'b1110001, 7'b0000001, 7'b1000001};
    run(f, -1, 1'b0, "overflow");

    f = mk_num(42, 2);
    f.pat[1*7 +: 7] = 7'b1010101;
    run(f, -1, 1'b0, "invalid_pos1");

    run(mk_num(1234, 4), -1, 1'b0, "clean_after_error");
    run(mk_num(73105, 5), 2, 1'b0, "glitch_pos2");

    for (int k = 0; k < 4; k++) run(mk_random(), -1, 1'b0, $sformatf("random%0d", k));

    run(mk_num(860417, 6), -1, 1'b1, "after_clear");
    run(mk_random(), -1, 1'b0, "random_tail");
    run(mk_num(5, 1), -1, 1'b0, "flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
